// File: rtl/wb_data_sel_buf_pkg.sv
// Shared constants, occupancy encoding and width helper for the buffered
// write-back data selector.
package wb_data_sel_buf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_N_SRC  = 7;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_sel_core.sv
// Combinational N_SRC-way source select with out-of-range detection.
module wb_sel_core
  import wb_data_sel_buf_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int N_SRC  = DEF_N_SRC,
  localparam int SEL_W  = clog2(N_SRC)
) (
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [N_SRC*DATA_W-1:0] i_data,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_oor
);

  // Out-of-range codes select nothing, so the result stays zero.
  always_comb begin
    o_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (int'(i_sel) == k) o_data = i_data[k*DATA_W +: DATA_W];
    end
  end

  assign o_oor = (int'(i_sel) >= N_SRC);

endmodule

// File: rtl/wb_data_sel_buf.sv
// Write-back data selector with valid/ready handshake through a two-entry
// skid buffer and a sticky out-of-range selector flag.
module wb_data_sel_buf
  import wb_data_sel_buf_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int N_SRC  = DEF_N_SRC,
  localparam int SEL_W  = clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        selector,
  input  logic [N_SRC*DATA_W-1:0] data_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       data_out,
  output logic [SEL_W-1:0]        src_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_main_data;
  logic [SEL_W-1:0]  r_main_src;
  logic [DATA_W-1:0] r_skid_data;
  logic [SEL_W-1:0]  r_skid_src;
  logic              r_sel_err;

  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_oor;
  logic              w_accept;
  logic              w_emit;

  wb_sel_core #(
    .DATA_W (DATA_W),
    .N_SRC  (N_SRC)
  ) u_core (
    .i_sel  (selector),
    .i_data (data_in),
    .o_data (w_sel_data),
    .o_oor  (w_sel_oor)
  );

  // Ready comes from registered state only, never from out_ready.
  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_emit    = out_valid & out_ready;

  assign data_out = r_main_data;
  assign src_out  = r_main_src;
  assign sel_err  = r_sel_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_src  <= '0;
      r_skid_data <= '0;
      r_skid_src  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_data <= w_sel_data;
            r_main_src  <= selector;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_emit) begin
            r_main_data <= w_sel_data;
            r_main_src  <= selector;
          end else if (w_accept) begin
            r_skid_data <= w_sel_data;
            r_skid_src  <= selector;
            r_state     <= ST_TWO;
          end else if (w_emit) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_emit) begin
            r_main_data <= r_skid_data;
            r_main_src  <= r_skid_src;
            r_state     <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // A new error on the same edge as a clear must win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && w_sel_oor) begin
      r_sel_err <= 1'b1;
    end else if (err_clr) begin
      r_sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_data_sel_buf.sv
// Directed bench for wb_data_sel_buf: scoreboard on the default instance plus
// slice checks on two alternate parameterisations.
module tb_wb_data_sel_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic reset = 1'b1;

  // Default instance: DATA_W=32, N_SRC=7, SEL_W=3
  logic [2:0]    selector  = '0;
  logic [223:0]  data_in   = '0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [31:0]   data_out;
  logic [2:0]    src_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          sel_err;
  logic          err_clr   = 1'b0;

  wb_data_sel_buf u_dut (
    .clk(clk), .reset(reset), .selector(selector), .data_in(data_in),
    .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
    .src_out(src_out), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err), .err_clr(err_clr)
  );

  // DATA_W=8, N_SRC=2
  logic        s8_sel = '0;
  logic [15:0] s8_din = '0;
  logic        s8_vld = 1'b0;
  logic        s8_rdy, s8_ov, s8_err, s8_src;
  logic [7:0]  s8_dout;

  wb_data_sel_buf #(.DATA_W(8), .N_SRC(2)) u_s8 (
    .clk(clk), .reset(reset), .selector(s8_sel), .data_in(s8_din),
    .in_valid(s8_vld), .in_ready(s8_rdy), .data_out(s8_dout),
    .src_out(s8_src), .out_valid(s8_ov), .out_ready(1'b1),
    .sel_err(s8_err), .err_clr(1'b0)
  );

  // DATA_W=64, N_SRC=9
  logic [3:0]   s64_sel = '0;
  logic [575:0] s64_din = '0;
  logic         s64_vld = 1'b0;
  logic         s64_rdy, s64_ov, s64_err;
  logic [3:0]   s64_src;
  logic [63:0]  s64_dout;

  wb_data_sel_buf #(.DATA_W(64), .N_SRC(9)) u_s64 (
    .clk(clk), .reset(reset), .selector(s64_sel), .data_in(s64_din),
    .in_valid(s64_vld), .in_ready(s64_rdy), .data_out(s64_dout),
    .src_out(s64_src), .out_valid(s64_ov), .out_ready(1'b1),
    .sel_err(s64_err), .err_clr(1'b0)
  );

  // Scoreboard entries are {src[2:0], data[31:0]}
  logic [34:0] q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input logic [31:0] base);
    for (int k = 0; k < 7; k++) data_in[k*32 +: 32] = base + 32'(k);
  endtask

  function automatic logic [31:0] model_sel(input logic [2:0] s, input logic [223:0] d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 7; k++) if (int'(s) == k) r = d[k*32 +: 32];
    return r;
  endfunction

  // Inputs change at posedge+1, so the negedge sees this cycle's handshake.
  always @(negedge clk) begin
    logic [34:0] e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $error("FAIL emit_unexpected observed=%0h expected=none", {src_out, data_out});
        end else begin
          e = q.pop_front();
          assert ({src_out, data_out} === e) else begin
            bad++;
            $error("FAIL emit_order observed=%0h expected=%0h", {src_out, data_out}, e);
          end
        end
      end
      if (in_valid && in_ready) q.push_back({selector, model_sel(selector, data_in)});
    end
  end

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Values held during reset
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data_out",  64'(data_out),  64'd0);
    check("rst_src_out",   64'(src_out),   64'd0);
    check("rst_sel_err",   64'(sel_err),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    tick();
    reset = 1'b0;
    tick();

    // Single transfer, latency 1
    set_src(32'h0000_00E0);
    out_ready = 1'b1;
    selector  = 3'd3;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data",  64'(data_out),  64'h0000_00E3);
    check("single_src",   64'(src_out),   64'd3);
    tick();
    check("single_drain", 64'(out_valid), 64'd0);

    // Streaming at one transfer per cycle
    set_src(32'h0000_0100);
    for (int k = 0; k < 7; k++) begin
      selector = 3'(k);
      in_valid = 1'b1;
      tick();
      check("stream_data",  64'(data_out), 64'(32'h100 + 32'(k)));
      check("stream_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain", 64'(out_valid), 64'd0);

    // Backpressure fills both entries, third item must wait
    set_src(32'h0000_0A00);
    out_ready = 1'b0;
    selector  = 3'd1;
    in_valid  = 1'b1;
    tick();
    check("bp_ready_one", 64'(in_ready), 64'd1);
    selector = 3'd2;
    tick();
    check("bp_ready_two", 64'(in_ready), 64'd0);
    selector = 3'd3;
    tick();
    tick();
    check("bp_hold_data",  64'(data_out),  64'h0000_0A01);
    check("bp_hold_src",   64'(src_out),   64'd1);
    check("bp_hold_ready", 64'(in_ready),  64'd0);
    out_ready = 1'b1;
    tick();
    check("bp_emit_b", 64'(data_out), 64'h0000_0A02);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_emit_c", 64'(data_out), 64'h0000_0A03);
    tick();
    check("bp_drain",  64'(out_valid), 64'd0);
    check("bp_hold_last", 64'(data_out), 64'h0000_0A03);
    check("bp_queue_empty", 64'(q.size()), 64'd0);

    // Out-of-range selector
    selector = 3'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("oor_data",    64'(data_out), 64'd0);
    check("oor_src",     64'(src_out),  64'd7);
    check("oor_sel_err", 64'(sel_err),  64'd1);
    tick();
    check("oor_sticky", 64'(sel_err), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("oor_clear", 64'(sel_err), 64'd0);
    err_clr  = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("oor_set_wins", 64'(sel_err), 64'd1);
    tick();
    err_clr = 1'b0;
    check("oor_clear2", 64'(sel_err), 64'd0);

    // Fill to TWO; a bad selector offered while full must be ignored
    out_ready = 1'b0;
    selector  = 3'd0;
    in_valid  = 1'b1;
    tick();
    selector = 3'd1;
    tick();
    selector = 3'd7;
    tick();
    check("full_ready",   64'(in_ready), 64'd0);
    check("full_no_err",  64'(sel_err),  64'd0);
    check("full_data",    64'(data_out), 64'h0000_0A00);

    // Asynchronous reset between edges
    in_valid = 1'b0;
    #1;
    reset = 1'b1;
    q.delete();
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_data_out",  64'(data_out),  64'd0);
    check("arst_sel_err",   64'(sel_err),   64'd0);
    check("arst_in_ready",  64'(in_ready),  64'd1);
    tick();
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    check("arst_no_stale",  64'(out_valid), 64'd0);
    check("arst_ready_rel", 64'(in_ready),  64'd1);

    // Parameter sweep: DATA_W=8 N_SRC=2
    s8_din = 16'hC35A;
    s8_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s8_sel = 1'(i);
      tick();
      check("s8_data", 64'(s8_dout), (i == 0) ? 64'h5A : 64'hC3);
      check("s8_src",  64'(s8_src),  64'(i));
      check("s8_err",  64'(s8_err),  64'd0);
    end
    s8_vld = 1'b0;

    // Parameter sweep: DATA_W=64 N_SRC=9, including codes 9..15
    for (int k = 0; k < 9; k++) s64_din[k*64 +: 64] = 64'hA5A5_0000_0000_0000 + 64'(k) * 64'h0101;
    s64_vld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s64_sel = 4'(i);
      tick();
      check("s64_data", s64_dout, (i < 9) ? 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0101 : 64'd0);
      check("s64_src",  64'(s64_src), 64'(i));
      check("s64_err",  64'(s64_err), (i < 9) ? 64'd0 : 64'd1);
    end
    s64_vld = 1'b0;
    tick();

    check("final_queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_data_sel_buf.md
Name: wb_data_sel_buf

Overview:
- Parametrised, buffered successor to the write-back data selector feeding the register file write port.
- Selects one of N_SRC data sources per transaction and registers the result.
- Carries a valid/ready handshake on both sides through a two-entry skid buffer, so multicycle control or pipeline stalls never drop or duplicate write-back data.
- Flags out-of-range selector codes instead of aliasing them onto a source.

Parameters:
- DATA_W, 32, width of each source and of the output.
- N_SRC, 7, number of selectable sources (>=2).
- SEL_W, derived localparam = clog2(N_SRC), selector width (3 at defaults). Not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- selector  in  SEL_W  source index, sampled with in_valid.
- data_in  in  N_SRC*DATA_W  packed sources; source k occupies bits [k*DATA_W +: DATA_W].
- in_valid  in  1  upstream offers selector+data this cycle.
- in_ready  out  1  block accepts this cycle.
- data_out  out  DATA_W  selected, registered data.
- src_out  out  SEL_W  selector value that produced data_out.
- out_valid  out  1  data_out/src_out valid.
- out_ready  in  1  register-file side consumes this cycle.
- sel_err  out  1  sticky: an out-of-range selector was accepted.
- err_clr  in  1  synchronous clear of sel_err.

Behaviour:
- Reset (async assert, values hold while reset is high): data_out=0, src_out=0, out_valid=0, sel_err=0, both buffer entries empty, in_ready=1.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- Selection on accept:
  - selector < N_SRC: entry data = data_in slice [selector].
  - selector >= N_SRC: entry data = 0, src = selector unchanged, sel_err set next edge.
- State machine on occupancy:
  - EMPTY: accept -> ONE. Data appears on data_out the next cycle (latency 1).
  - ONE, accept & emit: main entry reloads -> ONE (full throughput, 1 transfer/cycle).
  - ONE, accept & !emit: new item goes to skid entry -> TWO.
  - ONE, !accept & emit: -> EMPTY.
  - ONE, neither: hold.
  - TWO: in_ready=0. Emit: skid entry moves to main -> ONE. No emit: hold.
- in_ready = (state != TWO). It depends on registered state only, with no combinational path from out_ready.
- Ordering strictly FIFO. data_out/src_out stable while out_valid & !out_ready.
- Data in empty entries is don't-care internally, but data_out holds its last value after emit (not zeroed).
- sel_err: set and err_clr in the same cycle -> set wins (stays 1). err_clr alone -> 0 next edge.
- in_valid with no accept (state TWO) has no effect, including on sel_err.
- Reset asserted mid-transfer: buffered items discarded, outputs to reset values immediately. No emit occurs on that edge.

Decomposition:
- Shared package: clog2 function, the default width constants DATA_W=32 and N_SRC=7, and the occupancy state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
- One natural sub-module: wb_sel_core. It is combinational: N_SRC-way slice select plus range check, and outputs the selected data and an out-of-range flag.
- wb_data_sel_buf contains the two entry registers, the state machine and sel_err.

Test Plan:
- Reset then single transfer. Release reset; in_valid=1, selector=3, source3=0x0000_00E3, out_ready=1 -> next cycle out_valid=1, data_out=0x0000_00E3, src_out=3. Following cycle out_valid=0.
- Streaming. in_valid=1 and out_ready=1 for 7 cycles, selector 0..6, source k=0x100+k -> data_out 0x100..0x106 in order on consecutive cycles; in_ready stays 1.
- Backpressure. out_ready=0 while offering A (sel 1) and B (sel 2), then C -> in_ready drops after B. C is held, not accepted. Release out_ready -> emits A, B, C in order, no loss or duplicates.
- Out-of-range select. selector=7 with N_SRC=7 accepted -> data_out=0, src_out=7, sel_err=1. Pulse err_clr -> sel_err=0. Then err_clr and a bad select in the same cycle -> sel_err=1.
- Reset mid-operation. Reach state TWO, assert reset asynchronously between edges -> out_valid=0, data_out=0, sel_err=0 immediately. After release in_ready=1 and no stale item emerges.
- Parameter sweep. DATA_W=8, N_SRC=2 (SEL_W=1) and DATA_W=64, N_SRC=9 (SEL_W=4) -> every legal index returns its slice. For N_SRC=9, indices 9..15 yield 0 with sel_err set.
